// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack handshake, issue handshake with decode fields,
// and the branch-resolution inputs that steer the next PC.
interface ifetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            pcsrc;
    logic [XLEN-1:0] immext;
    logic            halted;
    logic [1:0]      fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, funct3, funct7b5,
               pc, pcplus4, halted, fault,
        input  imem_ack, imem_rdata, instr_ready, pcsrc, immext
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, funct3, funct7b5,
               pc, pcplus4, halted, fault,
        output imem_ack, imem_rdata, instr_ready, pcsrc, immext
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, issues one instruction at a time.
// Best case one instruction per 2 cycles; waits in FETCH for ack and in ISSUE for instr_ready.
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] instr_q, instr_nxt;
    logic [1:0]      fault_q, fault_nxt;
    logic [XLEN-1:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 2'b00;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            fault_q <= fault_nxt;
        end
    end

    // Both candidates wrap naturally at 2^XLEN.
    assign target = bus.pcsrc ? (pc_q + bus.immext) : (pc_q + XLEN'(4));

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        fault_nxt = fault_q;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_nxt = bus.imem_rdata;
                    if (bus.imem_rdata[1:0] == 2'b11) begin
                        state_nxt = ISSUE;
                    end else begin
                        fault_nxt = 2'b01;
                        state_nxt = HALT;
                    end
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    // A misaligned target halts with the PC still on the offending instruction.
                    if (target[1:0] != 2'b00) begin
                        fault_nxt = 2'b10;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state == ISSUE);
    assign bus.halted      = (state == HALT);
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[6:0];
    assign bus.funct3      = instr_q[14:12];
    assign bus.funct7b5    = instr_q[30];
    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pc_q + XLEN'(4);
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed plus randomized bench for ifetch_unit against a transaction-level PC/instruction model.
module tb_ifetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ifetch_unit_if #(.XLEN(32)) bus ();

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check everything the issue side presents for a given instruction word and PC.
    task automatic check_issue(input string tag, input logic [31:0] w, input logic [31:0] p);
        logic [31:0] wv;
        wv = w;
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        check({tag, "_instr"}, bus.instr, wv);
        check({tag, "_op"}, {25'd0, bus.op}, {25'd0, wv[6:0]});
        check({tag, "_f3"}, {29'd0, bus.funct3}, {29'd0, wv[14:12]});
        check({tag, "_f7b5"}, {31'd0, bus.funct7b5}, {31'd0, wv[30]});
        check({tag, "_pc"}, bus.pc, p);
        check({tag, "_pc4"}, bus.pcplus4, p + 32'd4);
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] a);
        check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        check({tag, "_addr"}, bus.imem_addr, a);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    endtask

    logic [31:0] exp_pc;

    initial begin
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        bus.instr_ready = 1'b1;
        bus.pcsrc       = 1'b0;
        bus.immext      = 32'd0;
        #12;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_fault", {30'd0, bus.fault}, 32'd0);
        check("rst_pc", bus.pc, 32'd0);
        check("rst_instr", bus.instr, 32'd0);

        // First fetch after reset release: one idle cycle, then back-to-back fetch/issue.
        rst_n = 1'b1;
        #2;
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check_fetch("f0", 32'h0);
        step();
        check_issue("i0", 32'h0000_0013, 32'h0);
        step();
        check_fetch("f4", 32'h4);
        step();
        check_issue("i4", 32'h0000_0013, 32'h4);
        bus.imem_ack = 1'b0;
        step();

        // Delayed ack at 0x8 with the request held, then stalled issue.
        for (int i = 0; i < 3; i++) begin
            check_fetch("f8wait", 32'h8);
            step();
        end
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h0050_0093;
        bus.instr_ready = 1'b0;
        step();
        bus.imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            check_issue("i8hold", 32'h0050_0093, 32'h8);
            step();
        end
        check_issue("i8", 32'h0050_0093, 32'h8);
        bus.instr_ready = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        step();
        check_fetch("fC", 32'hC);
        bus.pcsrc  = 1'b1;
        bus.immext = 32'h14;
        step();
        step();

        // Backward and fall-through around a beq at 0x20.
        check_fetch("f20a", 32'h20);
        bus.imem_rdata = 32'h0000_0063;
        bus.immext     = 32'hFFFF_FFF8;
        step();
        check_issue("i20a", 32'h0000_0063, 32'h20);
        step();
        check_fetch("f18", 32'h18);
        bus.imem_rdata = 32'h0000_0013;
        bus.immext     = 32'h8;
        step();
        step();
        check_fetch("f20b", 32'h20);
        bus.imem_rdata = 32'h0000_0063;
        bus.pcsrc      = 1'b0;
        step();
        check_issue("i20b", 32'h0000_0063, 32'h20);
        step();
        check_fetch("f24", 32'h24);

        // Sequential wrap from the top of the address space.
        bus.imem_rdata = 32'h0000_0013;
        bus.pcsrc      = 1'b1;
        bus.immext     = 32'hFFFF_FFD8;
        step();
        step();
        check_fetch("ftop", 32'hFFFF_FFFC);
        bus.pcsrc = 1'b0;
        step();
        check_issue("itop", 32'h0000_0013, 32'hFFFF_FFFC);
        step();
        check_fetch("fwrap", 32'h0);
        check("wrap_fault", {30'd0, bus.fault}, 32'd0);
        check("wrap_halted", {31'd0, bus.halted}, 32'd0);

        // Randomized traffic: the model tracks only the architectural PC sequence.
        exp_pc = 32'h0;
        for (int t = 0; t < 40; t++) begin
            int unsigned ad, rd;
            logic [31:0] w, imm;
            logic        br;
            ad  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            w   = $urandom | 32'h3;
            br  = 1'($urandom_range(0, 1));
            imm = 32'($signed($urandom_range(0, 127)) - 64) << 2;
            bus.imem_ack    = 1'b0;
            bus.instr_ready = 1'b0;
            for (int i = 0; i < int'(ad); i++) begin
                check_fetch("rnd_wait", exp_pc);
                step();
            end
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = w;
            check_fetch("rnd_ack", exp_pc);
            step();
            for (int i = 0; i <= int'(rd); i++) begin
                bus.imem_ack    = 1'($urandom_range(0, 1));
                bus.imem_rdata  = $urandom;
                bus.pcsrc       = 1'($urandom_range(0, 1));
                bus.immext      = $urandom;
                bus.instr_ready = (i == int'(rd));
                if (i == int'(rd)) begin
                    bus.pcsrc  = br;
                    bus.immext = imm;
                end
                check_issue("rnd_issue", w, exp_pc);
                step();
            end
            exp_pc = br ? exp_pc + imm : exp_pc + 32'd4;
        end
        check_fetch("rnd_end", exp_pc);

        // Misaligned branch target from 0x10 halts with pc held.
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        bus.instr_ready = 1'b1;
        bus.pcsrc       = 1'b1;
        bus.immext      = 32'h10 - exp_pc;
        step();
        step();
        check_fetch("f10", 32'h10);
        bus.immext = 32'h6;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check("mis_halted", {31'd0, bus.halted}, 32'd1);
            check("mis_fault", {30'd0, bus.fault}, 32'd2);
            check("mis_pc", bus.pc, 32'h10);
            check("mis_req", {31'd0, bus.imem_req}, 32'd0);
            check("mis_valid", {31'd0, bus.instr_valid}, 32'd0);
            step();
        end

        // Illegal encoding on the first fetch after reset.
        rst_n = 1'b0;
        #3;
        check("rst2_pc", bus.pc, 32'h0);
        check("rst2_fault", {30'd0, bus.fault}, 32'd0);
        check("rst2_halted", {31'd0, bus.halted}, 32'd0);
        rst_n          = 1'b1;
        bus.imem_rdata = 32'h0000_0000;
        bus.pcsrc      = 1'b0;
        step();
        check_fetch("fill", 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ill_halted", {31'd0, bus.halted}, 32'd1);
            check("ill_fault", {30'd0, bus.fault}, 32'd1);
            check("ill_valid", {31'd0, bus.instr_valid}, 32'd0);
            check("ill_req", {31'd0, bus.imem_req}, 32'd0);
        end

        // Reset asserted mid-FETCH drops the request without waiting for a clock edge.
        rst_n = 1'b0;
        #3;
        rst_n          = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();
        step();
        step();
        check_fetch("fpre", 32'h4);
        bus.imem_ack = 1'b0;
        step();
        check_fetch("fmid", 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, bus.imem_req}, 32'd0);
        check("arst_pc", bus.pc, 32'h0);
        #10;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch unit; the upstream end of the control path. It owns the PC and runs a req/ack handshake with instruction memory. It presents the fetched instruction and its decode fields (op, funct3, funct7b5) to the control unit. It consumes the control unit's pcsrc and the datapath's immext to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, width of PC, addresses, instruction and immediate.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address; equals pc
imem_ack  in  1  memory has returned data this cycle
imem_rdata  in  XLEN  instruction word; valid when imem_ack=1
instr_valid  out  1  instr and decode fields are valid
instr_ready  in  1  core executes the presented instruction this cycle
instr  out  XLEN  captured instruction word
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7b5  out  1  instr[30]
pc  out  XLEN  address of the presented instruction
pcplus4  out  XLEN  pc+4, mod 2^XLEN
pcsrc  in  1  branch taken; sampled only on the accept cycle
immext  in  XLEN  sign-extended branch offset; sampled with pcsrc
halted  out  1  unit stopped on a fault
fault  out  2  00 none, 01 illegal encoding, 10 misaligned target

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT. State, pc, instr and fault are registered.
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, instr=0, fault=00. Outputs: imem_req=0, instr_valid=0, halted=0.
- IDLE: all outputs inactive. Next clock goes to FETCH unconditionally; this is the first-fetch delay after reset release.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until ack. ack may arrive in the same cycle as req or any later cycle.
  - On imem_ack with imem_rdata[1:0]==2'b11: instr<=imem_rdata, go to ISSUE.
  - On imem_ack with imem_rdata[1:0]!=2'b11: instr<=imem_rdata, fault<=01, go to HALT.
- ISSUE: instr_valid=1 and imem_req=0. instr, op, funct3, funct7b5 and pc are held until accepted.
- Accept = ISSUE and instr_ready=1. next = pcsrc ? pc+immext : pc+4, both computed mod 2^XLEN.
  - If next[1:0]!=00: fault<=10, pc unchanged, go to HALT.
  - Otherwise pc<=next and go to FETCH.
- HALT: halted=1; imem_req=0; instr_valid=0. pc and instr keep the faulting values. Only reset exits HALT.
- imem_ack outside FETCH is ignored. pcsrc and immext outside an accept cycle are ignored.
- Throughput: at most one instruction per 2 cycles (FETCH with ack in same cycle, then ISSUE with ready in same cycle).
- Wrap: pc=0xFFFF_FFFC with pcsrc=0 gives next pc 0x0000_0000; this is legal and raises no fault.
- Reset mid-operation aborts any outstanding request; imem_req drops asynchronously. Instruction memory shares rst_n, so no stale ack is delivered after reset.
- op, funct3, funct7b5 and pcplus4 are combinational from instr and pc.

Test Plan:
- Reset release, imem_ack tied 1, instr_ready tied 1, imem_rdata=0x00000013 → cycle 1 IDLE; imem_req=1 with addr 0x0 on cycle 2; instr_valid on cycle 3; addr 0x4 on cycle 4.
- ack delayed 3 cycles at pc=0x8 → imem_req and imem_addr=0x8 stable all 3 cycles; instr_valid only after ack; instr_ready low for 2 cycles → pc and instr held.
- pc=0x20, instr 0x00000063 (beq), pcsrc=1, immext=0xFFFF_FFF8 on accept → next imem_addr=0x18. Same case with pcsrc=0 → 0x24.
- pc=0xFFFF_FFFC, pcsrc=0, accept → next fetch address 0x0, fault=00.
- pcsrc=1, immext=0x6 at pc=0x10 → halted=1, fault=10, pc stays 0x10, no further imem_req.
- imem_rdata=0x00000000 on ack → halted=1, fault=01, instr_valid never asserted. Then rst_n pulsed low mid-FETCH → imem_req drops immediately, and pc returns to RESET_PC.
